// File: rtl/sb_tx_scheduler.sv
// Sideband link controller: round-robin arbitration of NUM_REQ sources onto one serializer, plus RX done handshake.
// Latency: grant, data and clk_ser_en one edge after arbitration; rx_valid two edges after de_ser_done is first sampled.
// Backpressure: requesters hold req_valid/req_data until gnt; no new grant while busy or while sb_en is low.
module sb_tx_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_W     = 64,
  parameter int SER_CYCLES = 64,
  parameter int GAP_CYCLES = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         fifo_data_out,
  output logic                      clk_ser_en,
  output logic                      pack_finished,
  output logic                      busy,
  input  logic [DATA_W-1:0]         deser_data,
  input  logic                      de_ser_done,
  output logic                      de_ser_done_sampled,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid
);

  localparam int CNT_MAX = (SER_CYCLES > GAP_CYCLES) ? SER_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int RW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] SER_LAST = CW'(SER_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RR_INIT  = RW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [RW-1:0]       rr, rr_nxt;
  logic [RW-1:0]       win, idx;
  logic                found;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                ser_nxt, pf_nxt, busy_nxt;
  logic [DATA_W-1:0]   req_arr [NUM_REQ];
  logic                sync_s1, sync_s2;

  // Split the packed request bus into one packet per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin pick: first pending requester after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = RW'((int'(rr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Packet sequencer next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr;
    gnt_nxt   = '0;
    data_nxt  = fifo_data_out;
    ser_nxt   = clk_ser_en;
    pf_nxt    = pack_finished;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (sb_en && found) begin
          gnt_nxt   = NUM_REQ'(1) << win;
          data_nxt  = req_arr[win];
          ser_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          rr_nxt    = win;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (cnt == SER_LAST) begin
          cnt_nxt   = '0;
          ser_nxt   = 1'b0;
          pf_nxt    = 1'b1;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          pf_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, pointer and registered TX outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rr            <= RR_INIT;
      gnt           <= '0;
      fifo_data_out <= '0;
      clk_ser_en    <= 1'b0;
      pack_finished <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rr            <= rr_nxt;
      gnt           <= gnt_nxt;
      fifo_data_out <= data_nxt;
      clk_ser_en    <= ser_nxt;
      pack_finished <= pf_nxt;
      busy          <= busy_nxt;
    end
  end

  // RX: synchronize the foreign done level, capture once per assertion, ack until it drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1             <= 1'b0;
      sync_s2             <= 1'b0;
      de_ser_done_sampled <= 1'b0;
      rx_data             <= '0;
      rx_valid            <= 1'b0;
    end else begin
      sync_s1  <= de_ser_done;
      sync_s2  <= sync_s1;
      rx_valid <= 1'b0;
      if (sync_s2 && !de_ser_done_sampled) begin
        rx_data             <= deser_data;
        rx_valid            <= 1'b1;
        de_ser_done_sampled <= 1'b1;
      end else if (!sync_s2) begin
        de_ser_done_sampled <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sb_tx_scheduler.sv
module tb_sb_tx_scheduler;
  localparam int NR  = 3;
  localparam int DW  = 64;
  localparam int SER = 64;
  localparam int GAP = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sb_en;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [DW-1:0]    fifo_data_out;
  logic             clk_ser_en, pack_finished, busy;
  logic [DW-1:0]    deser_data;
  logic             de_ser_done, de_ser_done_sampled;
  logic [DW-1:0]    rx_data;
  logic             rx_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_rr;
  int last_g;
  int dl;
  logic [NR-1:0] pend;
  logic [DW-1:0] pdata [NR];

  sb_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .SER_CYCLES(SER), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .sb_en(sb_en), .req_valid(req_valid), .req_data(req_data),
    .gnt(gnt), .fifo_data_out(fifo_data_out), .clk_ser_en(clk_ser_en),
    .pack_finished(pack_finished), .busy(busy), .deser_data(deser_data),
    .de_ser_done(de_ser_done), .de_ser_done_sampled(de_ser_done_sampled),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req_valid = pend;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdata[i];
  endtask

  // Reference arbitration: first pending index after the previous winner.
  function automatic int pick(input logic [NR-1:0] v, input int rr);
    for (int k = 1; k <= NR; k++)
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_fifo"}, fifo_data_out, 0);
    check({tag, "_ser_en"}, clk_ser_en, 0);
    check({tag, "_pf"}, pack_finished, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_ack"}, de_ser_done_sampled, 0);
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (gnt !== '0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // One packet: expected winner from the model, then the 97-cycle output pattern measured from the grant.
  task automatic do_packet(input bit refill, input int inj_t, input logic [NR-1:0] inj_mask,
                           input bit inj_en, output int delta);
    int w, bad;
    logic [DW-1:0] d;
    logic [NR-1:0] oh;
    bit ok;
    delta = -1;
    w  = pick(pend, m_rr);
    d  = pdata[w];
    oh = NR'(1) << w;
    wait_gnt(ok);
    check("gnt_seen", ok, 1);
    if (!ok) return;
    delta  = cyc - last_g;
    last_g = cyc;
    check("gnt", gnt, oh);
    check("fifo_data_out", fifo_data_out, d);
    m_rr = w;
    if (refill) pdata[w] = {$urandom, $urandom};
    else pend[w] = 1'b0;
    apply();
    bad = 0;
    for (int t = 0; t <= SER + GAP; t++) begin
      if (t > 0) tick();
      if (t == inj_t) begin
        pend  = pend | inj_mask;
        sb_en = inj_en;
        apply();
      end
      if (clk_ser_en !== (t < SER) || pack_finished !== (t >= SER && t < SER + GAP) ||
          busy !== (t < SER + GAP) || gnt !== ((t == 0) ? oh : '0) || fifo_data_out !== d)
        bad++;
    end
    check("pkt_shape", bad, 0);
  endtask

  task automatic rx_xfer(input logic [DW-1:0] d, input int hold);
    int first, pulses, n;
    deser_data  = d;
    de_ser_done = 1'b1;
    first  = -1;
    pulses = 0;
    for (int e = 1; e <= hold; e++) begin
      tick();
      if (rx_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    check("rx_latency", first, 3);
    check("rx_pulses", pulses, 1);
    check("rx_data", rx_data, d);
    check("rx_ack_high", de_ser_done_sampled, 1);
    de_ser_done = 1'b0;
    n = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (n == 0 && de_ser_done_sampled === 1'b0) n = e;
    end
    check("rx_ack_fall", n, 3);
    deser_data = ~d;
    tick();
    check("rx_data_hold", rx_data, d);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    m_rr = NR - 1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int bad;
    bit ok;
    int w;
    rst_n = 1'b0;
    sb_en = 1'b1;
    pend  = '0;
    for (int i = 0; i < NR; i++) pdata[i] = '0;
    de_ser_done = 1'b0;
    deser_data  = '0;
    apply();
    m_rr   = NR - 1;
    last_g = 0;
    #3;
    check_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from source 0.
    pdata[0] = 64'hA5A5_0000_1234_5678;
    pend = 3'b001;
    apply();
    do_packet(1'b0, -1, '0, 1'b1, dl);

    // All three request after reset: 0, 1, 2 with 97-cycle spacing.
    reset_dut();
    for (int i = 0; i < NR; i++) pdata[i] = {$urandom, $urandom};
    pend = 3'b111;
    apply();
    do_packet(1'b0, -1, '0, 1'b1, dl);
    do_packet(1'b0, -1, '0, 1'b1, dl);
    check("b2b_spacing_1", dl, SER + GAP + 1);
    do_packet(1'b0, -1, '0, 1'b1, dl);
    check("b2b_spacing_2", dl, SER + GAP + 1);

    // Sources 0 and 2 always pending: alternate, source 1 never served.
    pdata[0] = {$urandom, $urandom};
    pdata[2] = {$urandom, $urandom};
    pend = 3'b101;
    apply();
    for (int i = 0; i < 4; i++) do_packet(1'b1, -1, '0, 1'b1, dl);
    pend = '0;
    apply();

    // Request arriving during gap cycle 10 waits for IDLE.
    pdata[1] = {$urandom, $urandom};
    pdata[0] = {$urandom, $urandom};
    pend = 3'b010;
    apply();
    do_packet(1'b0, SER + 10, 3'b001, 1'b1, dl);
    do_packet(1'b0, -1, '0, 1'b1, dl);
    check("midgap_gnt_delay", dl, SER + GAP + 1);

    // sb_en dropped mid-packet: packet completes, no further grant until re-enabled.
    pdata[2] = {$urandom, $urandom};
    pend = 3'b100;
    apply();
    do_packet(1'b1, 30, '0, 1'b0, dl);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt !== '0 || busy !== 1'b0 || clk_ser_en !== 1'b0) bad++;
    end
    check("sb_en_off_hold", bad, 0);
    sb_en = 1'b1;
    do_packet(1'b0, -1, '0, 1'b1, dl);
    check("sb_en_resume_delay", dl, SER + GAP + 21);

    // RX handshake, directed then random.
    rx_xfer(64'hDEAD_BEEF_CAFE_F00D, 10);
    for (int i = 0; i < 3; i++) rx_xfer({$urandom, $urandom}, $urandom_range(3, 12));

    // Reset during SEND cycle 20.
    pdata[0] = {$urandom, $urandom};
    pend = 3'b001;
    apply();
    w = pick(pend, m_rr);
    wait_gnt(ok);
    check("rst_mid_gnt", gnt, NR'(1) << w);
    pend = '0;
    apply();
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    m_rr = NR - 1;
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt !== '0 || busy !== 1'b0) bad++;
    end
    check("rst_mid_no_regrant", bad, 0);
    pdata[1] = {$urandom, $urandom};
    pend = 3'b010;
    apply();
    do_packet(1'b0, -1, '0, 1'b1, dl);

    // Random traffic against the model.
    for (int i = 0; i < 8; i++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 7));
      for (int j = 0; j < NR; j++)
        if (m[j] && !pend[j]) pdata[j] = {$urandom, $urandom};
      pend = pend | m;
      apply();
      do_packet(1'($urandom_range(0, 1)), -1, '0, 1'b1, dl);
      if (i > 0) check("rand_spacing", dl, SER + GAP + 1);
    end
    pend = '0;
    apply();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
